key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_if.sv | 21 ++
 rtl/key_debounce.sv | 129 ++++++++++++
 tb/tb_key_debounce.sv | 133 +++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Raw and debounced key levels for the key debouncer (all active-low).
interface key_debounce_if;
  logic KeyPlusRaw;
  logic KeyMinusRaw;
  logic KeyEditRaw;
  logic KeySwiRaw;
  logic KeyPlus;
  logic KeyMinus;
  logic KeyEdit;
  logic KeySwi;

  modport master (
    output KeyPlusRaw, KeyMinusRaw, KeyEditRaw, KeySwiRaw,
    input  KeyPlus, KeyMinus, KeyEdit, KeySwi
  );

  modport slave (
    input  KeyPlusRaw, KeyMinusRaw, KeyEditRaw, KeySwiRaw,
    output KeyPlus, KeyMinus, KeyEdit, KeySwi
  );
endinterface

// File: rtl/key_debounce.sv
// Four-key synchronizer + debouncer with optional auto-repeat on KeyPlus/KeyMinus.
// Auto-repeat is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce #(
  parameter int unsigned DB_CYCLES     = 50000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic           clk,
  input  logic           reset,
  key_debounce_if.slave  keys
);

  localparam int unsigned NKEYS = 4;
  localparam int unsigned DBW   = $clog2(DB_CYCLES) + 1;

  // Bit order: 0 plus, 1 minus, 2 edit, 3 swi
  logic [NKEYS-1:0] raw;
  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] sync2;
  logic [NKEYS-1:0] stable;
  logic [NKEYS-1:0] out_q;
  logic [NKEYS-1:0] rpt_mask_c;
  logic [DBW-1:0]   db_cnt [NKEYS];

  assign raw = {keys.KeySwiRaw, keys.KeyEditRaw, keys.KeyMinusRaw, keys.KeyPlusRaw};

  // Synchronize, then accept a new level only after DB_CYCLES unbroken cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      for (int i = 0; i < NKEYS; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NKEYS; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPW   = 25;
  localparam int unsigned NRPT  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  rpt_state_t     rpt_state [NRPT];
  logic [RPW-1:0] rpt_cnt   [NRPT];
  logic [NRPT-1:0] pulse_c;

  // Terminal count while still held raises the output for one cycle
  always_comb begin
    pulse_c = '0;
    for (int i = 0; i < NRPT; i++) begin
      if (!stable[i]) begin
        case (rpt_state[i])
          HOLD:    pulse_c[i] = (rpt_cnt[i] == RPW'(REPEAT_DELAY - 1));
          REPEAT:  pulse_c[i] = (rpt_cnt[i] == RPW'(REPEAT_PERIOD - 1));
          default: pulse_c[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NRPT; i++) begin
        rpt_state[i] <= IDLE;
        rpt_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NRPT; i++) begin
        case (rpt_state[i])
          IDLE: begin
            rpt_cnt[i] <= '0;
            if (!stable[i]) rpt_state[i] <= HOLD;
          end
          HOLD, REPEAT: begin
            if (stable[i]) begin
              rpt_state[i] <= IDLE;
              rpt_cnt[i]   <= '0;
            end else if (pulse_c[i]) begin
              rpt_state[i] <= REPEAT;
              rpt_cnt[i]   <= '0;
            end else begin
              rpt_cnt[i] <= rpt_cnt[i] + RPW'(1);
            end
          end
          default: begin
            rpt_state[i] <= IDLE;
            rpt_cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign rpt_mask_c = {2'b00, pulse_c};
`else
  // Repeat timing has no effect when auto-repeat is not built
  localparam int unsigned unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD;

  assign rpt_mask_c = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) out_q <= '1;
    else        out_q <= stable | rpt_mask_c;
  end

  assign keys.KeyPlus  = out_q[0];
  assign keys.KeyMinus = out_q[1];
  assign keys.KeyEdit  = out_q[2];
  assign keys.KeySwi   = out_q[3];

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/repeat timing.
module tb_key_debounce;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  key_debounce_if keys ();

  key_debounce #(
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .keys  (keys.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {keys.KeySwi, keys.KeyEdit, keys.KeyMinus, keys.KeyPlus};
  endfunction

  // Bit order: 0 plus, 1 minus, 2 edit, 3 swi
  task automatic set_raw(input logic [3:0] r);
    keys.KeyPlusRaw  = r[0];
    keys.KeyMinusRaw = r[1];
    keys.KeyEditRaw  = r[2];
    keys.KeySwiRaw   = r[3];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    tick();
    check_eq(tag, 32'(outs()), 32'hF);
    reset = 1'b1;
  endtask

  function automatic logic exp_plus_held(input int e);
    if (e < 6 || e >= 36) return 1'b1;
`ifdef KEY_AUTOREPEAT_EN
    if (e >= 16 && ((e - 16) % 5) == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  initial begin
    logic [3:0] exp;
    set_raw(4'hF);

    // Reset with every key pressed; edit falls 7 edges after the reset edge
    set_raw(4'h0);
    do_reset("rst_all_low");
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_eq($sformatf("rst_edit_e%0d", e), 32'(keys.KeyEdit), (e >= 7) ? 32'd0 : 32'd1);
    end
    set_raw(4'hF);
    do_reset("rst_a");

    // Edit press held 20 cycles then released
    set_raw(4'b1011);
    for (int e = 0; e <= 30; e++) begin
      if (e == 20) set_raw(4'hF);
      tick();
      exp = {1'b1, (e >= 6 && e < 26) ? 1'b0 : 1'b1, 2'b11};
      check_eq($sformatf("edit_e%0d", e), 32'(outs()), 32'(exp));
    end
    do_reset("rst_b");

    // Short swi glitch is ignored
    for (int e = 0; e <= 15; e++) begin
      set_raw({(e < 3) ? 1'b0 : 1'b1, 3'b111});
      tick();
      check_eq($sformatf("swi_short_e%0d", e), 32'(outs()), 32'hF);
    end
    do_reset("rst_c");

    // Swi bouncing every 2 cycles is ignored
    for (int e = 0; e <= 29; e++) begin
      set_raw({(e < 20 && ((e / 2) % 2) == 0) ? 1'b0 : 1'b1, 3'b111});
      tick();
      check_eq($sformatf("swi_bounce_e%0d", e), 32'(outs()), 32'hF);
    end
    do_reset("rst_d");

    // Plus held 30 cycles: auto-repeat pulses when built
    for (int e = 0; e <= 40; e++) begin
      set_raw({3'b111, (e < 30) ? 1'b0 : 1'b1});
      tick();
      exp = {3'b111, exp_plus_held(e)};
      check_eq($sformatf("plus_e%0d", e), 32'(outs()), 32'(exp));
    end
    do_reset("rst_e");

    // Plus+minus together, reset mid-hold restarts the full latency
    for (int e = 0; e <= 24; e++) begin
      set_raw(4'b1100);
      reset = (e == 14) ? 1'b0 : 1'b1;
      tick();
      if (e < 6 || (e >= 14 && e < 21)) exp = 4'hF;
      else                              exp = 4'b1100;
      check_eq($sformatf("dual_e%0d", e), 32'(outs()), 32'(exp));
    end
    reset = 1'b1;
    set_raw(4'hF);
    do_reset("rst_f");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
